irq_ctrl: RTL

// - Interrupt controller upstream of maindec: collects external sources (timer flag, debounced buttons),

---
 rtl/irq_ctrl_pkg.sv | 20 ++
 rtl/irq_ctrl_prio_enc.sv | 21 ++
 rtl/irq_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: bus addresses, FSM encodings and
// status-register field positions.
package irq_ctrl_pkg;

    localparam logic [4:0] A_STATUS = 5'b11000;
    localparam logic [4:0] A_MASK   = 5'b11001;
    localparam logic [4:0] A_CLEAR  = 5'b11010;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StReq     = 2'b01,
        StService = 2'b10
    } state_e;

    // Status word: {16'b0, state, 2'b0, irq_id, 1'b0, pending[7:0]}
    localparam int unsigned StatusPendLsb  = 0;
    localparam int unsigned StatusIdLsb    = 9;
    localparam int unsigned StatusStateLsb = 14;

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of req and whether any bit is set.
module irq_ctrl_prio_enc #(
    parameter int unsigned Width = 4
) (
    input  logic [Width-1:0] req,
    output logic [2:0]       idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int unsigned i = 0; i < Width; i++) begin
            if (req[i] && !any) begin
                any = 1'b1;
                idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-latched pending sources, mask, fixed-priority select and a
// non-nesting request/service handshake towards the CPU, plus a small register window.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned NSRC     = 4,
    parameter logic [7:0]  VEC_MASK = 8'h01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src,
    input  logic            we,
    input  logic [4:0]      addr,
    input  logic [31:0]     wd,
    output logic [31:0]     rd,
    input  logic            int_ack,
    input  logic            eret,
    output logic            irq,
    output logic            iv,
    output logic [2:0]      irq_id
);

    logic [NSRC-1:0] src_q;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [2:0]      irq_id_q, irq_id_d;
    state_e          state_q, state_d;

    logic [NSRC-1:0] src_rise;
    logic [NSRC-1:0] sw_clr;
    logic [7:0]      ack_clr8;
    logic [7:0]      act8;
    logic [7:0]      pending8;
    logic [2:0]      sel;
    logic            any_act;
    logic            take_ack;
    logic            unused_wd;

    assign unused_wd = ^wd[31:NSRC];

    always_comb begin
        act8 = '0;
        act8[NSRC-1:0] = pending_q & mask_q;
        pending8 = '0;
        pending8[NSRC-1:0] = pending_q;
    end

    irq_ctrl_prio_enc #(
        .Width (NSRC)
    ) u_prio_enc (
        .req (act8[NSRC-1:0]),
        .idx (sel),
        .any (any_act)
    );

    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        take_ack = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_act) begin
                    state_d  = StReq;
                    irq_id_d = sel;
                end
            end
            StReq: begin
                // Software withdrew the source before the CPU took it: drop the request.
                if (!act8[irq_id_q]) begin
                    state_d = StIdle;
                end else if (int_ack) begin
                    state_d  = StService;
                    take_ack = 1'b1;
                end
            end
            StService: begin
                if (eret) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        src_rise = src & ~src_q;
        sw_clr   = '0;
        if (we && addr == A_CLEAR) begin
            sw_clr = wd[NSRC-1:0];
        end
        ack_clr8 = '0;
        ack_clr8[irq_id_q] = take_ack;
        // A new edge in the same cycle as any clear keeps the bit set.
        pending_d = (pending_q & ~(sw_clr | ack_clr8[NSRC-1:0])) | src_rise;
        mask_d = mask_q;
        if (we && addr == A_MASK) begin
            mask_d = wd[NSRC-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            irq_id_q  <= '0;
            state_q   <= StIdle;
        end else begin
            src_q     <= src;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            irq_id_q  <= irq_id_d;
            state_q   <= state_d;
        end
    end

    assign irq    = (state_q == StReq);
    assign iv     = ((state_q == StReq) || (state_q == StService)) && VEC_MASK[irq_id_q];
    assign irq_id = irq_id_q;

    always_comb begin
        rd = 32'h0;
        if (addr == A_STATUS) begin
            rd[StatusPendLsb +: 8]  = pending8;
            rd[StatusIdLsb +: 3]    = irq_id_q;
            rd[StatusStateLsb +: 2] = state_q;
        end else if (addr == A_MASK) begin
            rd[NSRC-1:0] = mask_q;
        end
    end

endmodule
